// File: rtl/ws2812_grid_driver.sv
// ws2812_grid_driver: snapshots the Life grid and colours, then serializes one GRB frame onto a WS2812 chain.
// Define SERPENTINE_EN for zig-zag matrix wiring, where odd rows are transmitted right-to-left.
module ws2812_grid_driver #(
  parameter int NUM_CELLS = 64,
  parameter int GRID_W    = 8,
  parameter int T0H_CYC   = 35,
  parameter int T1H_CYC   = 70,
  parameter int TBIT_CYC  = 125,
  parameter int TRES_CYC  = 5000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] cells,
  input  logic [23:0]          alive,
  input  logic [23:0]          dead,
  output logic                 busy,
  output logic                 done,
  output logic                 dout
);
`ifdef SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif
  localparam int CMAX = TRES_CYC > TBIT_CYC ? TRES_CYC : TBIT_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam int PW   = NUM_CELLS > 1 ? $clog2(NUM_CELLS) : 1;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [PW-1:0]        pix_q, pix_d;
  logic [4:0]           bit_q, bit_d;
  logic [NUM_CELLS-1:0] cells_q, cells_d;
  logic [23:0]          alive_q, alive_d, dead_q, dead_d;
  logic                 busy_q, busy_d, done_q, done_d, dout_q, dout_d;
  logic [31:0]          p, r, c;
  logic [PW-1:0]        idx;
  logic [23:0]          col, word;
  logic                 cur;
  always_comb begin
    p    = 32'(pix_q);
    r    = p / GRID_W;
    c    = p % GRID_W;
    idx  = (SERP && r[0]) ? PW'(r * GRID_W + GRID_W - 1 - c) : pix_q;
    col  = cells_q[idx] ? alive_q : dead_q;
    word = {col[15:8], col[23:16], col[7:0]};
    cur  = word[bit_q];
  end
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    pix_d   = pix_q;
    bit_d   = bit_q;
    cells_d = cells_q;
    alive_d = alive_q;
    dead_d  = dead_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (start) begin
          state_d = HIGH;
          pix_d   = '0;
          bit_d   = 5'd23;
          cells_d = cells;
          alive_d = alive;
          dead_d  = dead;
        end
      end
      HIGH: state_d = (cyc_q == CW'((cur ? T1H_CYC : T0H_CYC) - 1)) ? LOW : HIGH;
      LOW: begin
        if (cyc_q == CW'(TBIT_CYC - 1)) begin
          cyc_d   = '0;
          state_d = (bit_q == 5'd0 && pix_q == PW'(NUM_CELLS - 1)) ? GAP : HIGH;
          bit_d   = (bit_q == 5'd0) ? 5'd23 : bit_q - 5'd1;
          pix_d   = (bit_q == 5'd0 && pix_q != PW'(NUM_CELLS - 1)) ? pix_q + 1'b1 : pix_q;
        end
      end
      default: begin
        if (cyc_q == CW'(TRES_CYC - 1)) begin
          state_d = IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end
      end
    endcase
    busy_d = state_d != IDLE;
    dout_d = state_d == HIGH;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      pix_q   <= '0;
      bit_q   <= '0;
      cells_q <= '0;
      alive_q <= '0;
      dead_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pix_q   <= pix_d;
      bit_q   <= bit_d;
      cells_q <= cells_d;
      alive_q <= alive_d;
      dead_q  <= dead_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
endmodule

// File: tb/tb_ws2812_grid_driver.sv
// tb_ws2812_grid_driver: directed frames; a monitor decodes dout into words and checks them against a queue of expected GRB words.
module tb_ws2812_grid_driver;
`ifdef SERPENTINE_EN
  localparam int SP = 3;
`else
  localparam int SP = 2;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, start_s = 1'b0;
  logic [1:0]  cells = '0;
  logic [3:0]  cells_s = '0;
  logic [23:0] alive = '0, dead = '0;
  logic        busy, done, dout, busy_s, done_s, dout_s;
  int          n_cmp = 0, n_bad = 0, n_done = 0;
  logic [24:0] exp_q[$];

  ws2812_grid_driver #(.NUM_CELLS(2), .GRID_W(2), .T0H_CYC(2), .T1H_CYC(4), .TBIT_CYC(6), .TRES_CYC(10)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cells(cells), .alive(alive), .dead(dead),
    .busy(busy), .done(done), .dout(dout));

  ws2812_grid_driver #(.NUM_CELLS(4), .GRID_W(2), .T0H_CYC(2), .T1H_CYC(4), .TBIT_CYC(6), .TRES_CYC(10)) u_serp (
    .clk(clk), .reset_n(reset_n), .start(start_s), .cells(cells_s), .alive(alive), .dead(dead),
    .busy(busy_s), .done(done_s), .dout(dout_s));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 1000) begin
      step();
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic push(input logic [23:0] w);
    exp_q.push_back({1'b1, w});
  endtask

  logic        m_prev = 1'b0, m_in = 1'b0, m_ok = 1'b1;
  int          m_hl = 0, m_per = 0, m_nb = 0, m_t = 0;
  logic [23:0] m_sh = '0;
  logic [24:0] m_e;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      m_prev = 1'b0; m_in = 1'b0; m_ok = 1'b1; m_hl = 0; m_per = 0; m_nb = 0;
    end else begin
      if (m_in) m_t++;
      if (done) begin
        n_done++;
        chk("frame_len", 32'(m_t), 32'd298);
        chk("busy_at_done", 32'(busy), 32'd0);
        m_in = 1'b0;
      end
      if (dout && !m_prev) begin
        if (m_in && m_per != 6) m_ok = 1'b0;
        if (!m_in) begin
          m_in = 1'b1;
          m_t  = 0;
        end
        m_per = 1;
        m_hl  = 1;
      end else begin
        m_per++;
        if (dout) m_hl++;
      end
      if (!dout && m_prev) begin
        if (m_hl != 2 && m_hl != 4) m_ok = 1'b0;
        m_sh = {m_sh[22:0], m_hl == 4};
        m_nb++;
        if (m_nb == 24) begin
          m_e = (exp_q.size() != 0) ? exp_q.pop_front() : 25'h0;
          chk("word", 32'({m_ok, m_sh}), 32'(m_e));
          m_nb = 0;
          m_ok = 1'b1;
        end
      end
      m_prev = dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    // reset held with start high, then accepted on the first edge after release
    start = 1'b1; cells = 2'b01; alive = 24'hFF0000; dead = 24'h0000FF;
    repeat (3) step();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    push(24'h00FF00);
    push(24'h0000FF);
    reset_n = 1'b1;
    step();
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_dout", 32'(dout), 32'd1);
    start = 1'b0;
    wait_done("done_basic");
    step();
    // snapshot: inputs toggle every cycle after acceptance
    cells = 2'b10; alive = 24'h123456; dead = 24'hABCDEF; start = 1'b1;
    push(24'hCDABEF);
    push(24'h341256);
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      alive ^= 24'hFFFFFF; dead ^= 24'hFFFFFF; cells ^= 2'b11;
      step();
    end
    chk("done_snapshot", 32'(done), 32'd1);
    step();
    // abort in pixel 0, bit 10
    cells = 2'b01; alive = 24'h00FF00; dead = 24'h000000; start = 1'b1;
    push(24'hFF0000);
    push(24'h000000);
    step();
    start = 1'b0;
    repeat (78) step();
    chk("bit10_high", 32'(dout), 32'd1);
    reset_n = 1'b0;
    step();
    exp_q.delete();
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    reset_n = 1'b1;
    repeat (20) step();
    chk("abort_no_done", 32'(n_done), 32'd2);
    cells = 2'b11; alive = 24'hA5C3F0; start = 1'b1;
    push(24'hC3A5F0);
    push(24'hC3A5F0);
    step();
    start = 1'b0;
    wait_done("done_restart");
    step();
    // start held high: ignored while busy, accepted again right after done
    cells = 2'b00; dead = 24'h010203; alive = 24'hFFFFFF; start = 1'b1;
    push(24'h020103);
    push(24'h020103);
    push(24'h0F0F0F);
    push(24'h0F0F0F);
    step();
    cells = 2'b11; alive = 24'h0F0F0F;
    wait_done("done_b2b_1");
    step();
    chk("b2b_dout", 32'(dout), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("done_b2b_2");
    step();
    // pixel order on a 2x2 matrix: only cell 2 is alive
    cells_s = 4'b0100; alive = 24'hFF0000; dead = 24'h000000; start_s = 1'b1;
    step();
    start_s = 1'b0;
    off = 0;
    for (int p = 0; p < 4; p++) begin
      while (off < p * 144 + 50) begin
        step();
        off++;
      end
      chk($sformatf("serp_pix%0d", p), 32'(dout_s), 32'(p == SP));
    end
    for (int n = 0; n < 1000 && !done_s; n++) step();
    chk("serp_done", 32'(done_s), 32'd1);
    chk("serp_busy", 32'(busy_s), 32'd0);
    repeat (3) step();
    chk("done_count", 32'(n_done), 32'd5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
